// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_gen
// Description : Registered active-low LED pattern driver. Decodes a switch
//               index to a one-cold LED pattern. Also provides a prescaled
//               running light (chase up / chase down) and an optional blink
//               mode.
//               Optional feature macro: LED_PATTERN_BLINK_EN.
//               When it is undefined, mode 3 behaves as static decode.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_gen #(
    parameter int LED_N    = 8,
    parameter int SEL_W    = 3,
    parameter int TICK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [SEL_W-1:0] switch,
    input  logic [1:0]       mode,
    output logic [LED_N-1:0] led
);

    localparam int POS_W = $clog2(LED_N);
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [POS_W-1:0] POS_MAX   = POS_W'(LED_N - 1);
    localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(TICK_DIV - 1);
    localparam logic [SEL_W:0]   LED_N_EXT = (SEL_W + 1)'(LED_N);
    localparam logic [LED_N-1:0] ALL_OFF   = '1;
    localparam logic [LED_N-1:0] BIT0      = LED_N'(1);

    localparam logic [1:0] MODE_STATIC = 2'd0;
    localparam logic [1:0] MODE_UP     = 2'd1;
    localparam logic [1:0] MODE_DOWN   = 2'd2;

    // One-cold decode. Indices beyond the LED count shift the single bit out,
    // which leaves every LED dark.
    function automatic logic [LED_N-1:0] dec(input logic [SEL_W-1:0] idx);
        return ~(BIT0 << idx);
    endfunction

    logic [POS_W-1:0] pos, pos_nxt;
    logic [PRE_W-1:0] pre, pre_nxt;
    logic             phase, phase_nxt;
    logic [LED_N-1:0] led_nxt;

    logic             tick;
    logic [POS_W-1:0] sw_clamp;
    logic [POS_W-1:0] pos_up;
    logic [POS_W-1:0] pos_dn;

    // Step strobe and candidate positions shared by all modes.
    always_comb begin
        tick     = enable && (pre == PRE_MAX);
        sw_clamp = ({1'b0, switch} < LED_N_EXT) ? POS_W'(switch) : POS_MAX;
        pos_up   = (pos == POS_MAX) ? '0 : pos + POS_W'(1);
        pos_dn   = (pos == '0) ? POS_MAX : pos - POS_W'(1);
    end

    // Next-state selection; with enable low everything holds.
    always_comb begin
        pre_nxt   = pre;
        pos_nxt   = pos;
        phase_nxt = phase;
        led_nxt   = led;
        if (enable) begin
            // The prescaler free-runs regardless of mode.
            pre_nxt = tick ? '0 : pre + PRE_W'(1);
            case (mode)
                MODE_UP: begin
                    if (tick) begin
                        pos_nxt = pos_up;
                        led_nxt = dec(SEL_W'(pos_up));
                    end
                end
                MODE_DOWN: begin
                    if (tick) begin
                        pos_nxt = pos_dn;
                        led_nxt = dec(SEL_W'(pos_dn));
                    end
                end
`ifdef LED_PATTERN_BLINK_EN
                MODE_STATIC: begin
                    pos_nxt   = sw_clamp;
                    phase_nxt = 1'b0;
                    led_nxt   = dec(switch);
                end
                default: begin
                    // Blink: dark half-period while the upcoming phase is 1.
                    pos_nxt   = sw_clamp;
                    phase_nxt = tick ? ~phase : phase;
                    led_nxt   = phase_nxt ? ALL_OFF : dec(switch);
                end
`else
                default: begin
                    // Static decode (mode 3 aliases mode 0 without blink).
                    pos_nxt   = sw_clamp;
                    phase_nxt = 1'b0;
                    led_nxt   = dec(switch);
                end
`endif
            endcase
        end
    end

    // State and output registers; reset dominates enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos   <= '0;
            pre   <= '0;
            phase <= 1'b0;
            led   <= ALL_OFF;
        end else begin
            pos   <= pos_nxt;
            pre   <= pre_nxt;
            phase <= phase_nxt;
            led   <= led_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_pattern_gen
// Description : Directed self-checking bench for led_pattern_gen (8-LED and
//               6-LED instances sharing the same stimulus).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pattern_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic [2:0] switch = 3'd0;
    logic [1:0] mode = 2'd0;
    logic [7:0] led;
    logic [5:0] led6;

    int total = 0;
    int bad   = 0;

    led_pattern_gen #(.LED_N(8), .SEL_W(3), .TICK_DIV(4)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .switch(switch), .mode(mode), .led(led)
    );

    led_pattern_gen #(.LED_N(6), .SEL_W(3), .TICK_DIV(4)) dut6 (
        .clk(clk), .rst(rst), .enable(enable),
        .switch(switch), .mode(mode), .led(led6)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Synchronous reset pulse; afterwards the prescaler is at 0.
    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    logic [7:0] sweep_tbl [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [7:0] up_tbl    [4] = '{8'hBF, 8'h7F, 8'hFE, 8'hFD};
    logic [7:0] dn_tbl    [4] = '{8'hFD, 8'hFE, 8'h7F, 8'hBF};
    logic [5:0] sweep6    [8] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F, 6'h3F, 6'h3F};

    bit blink_en;

    initial begin
`ifdef LED_PATTERN_BLINK_EN
        blink_en = 1'b1;
`else
        blink_en = 1'b0;
`endif
        // Reset behaviour.
        rst = 1'b1; mode = 2'd0; switch = 3'd3; enable = 1'b1;
        #1;
        step();
        check("rst_c1", led, 8'hFF);
        step();
        check("rst_c2", led, 8'hFF);
        rst = 1'b0;
        step();
        check("rst_release", led, 8'hF7);

        // Static sweep, one cycle latency.
        for (int s = 0; s < 8; s++) begin
            switch = 3'(s);
            step();
            check($sformatf("static_%0d", s), led, sweep_tbl[s]);
            check($sformatf("static6_%0d", s), {2'b00, led6}, {2'b00, sweep6[s]});
        end

        // Chase up from 6 with wrap; k counts enabled edges since reset.
        do_reset();
        mode = 2'd0; switch = 3'd6;
        step();
        check("up_load", led, 8'hBF);
        mode = 2'd1;
        for (int k = 2; k <= 15; k++) begin
            step();
            check($sformatf("up_k%0d", k), led, up_tbl[k/4]);
        end

        // Chase down from 1 with wrap.
        do_reset();
        mode = 2'd0; switch = 3'd1;
        step();
        check("dn_load", led, 8'hFD);
        mode = 2'd2;
        for (int k = 2; k <= 15; k++) begin
            step();
            check($sformatf("dn_k%0d", k), led, dn_tbl[k/4]);
        end

        // Freeze mid chase-up; pre is 2 when enable drops.
        do_reset();
        mode = 2'd0; switch = 3'd0;
        step();
        mode = 2'd1;
        for (int k = 2; k <= 6; k++) step();
        check("frz_before", led, 8'hFD);
        enable = 1'b0; mode = 2'd0; switch = 3'd5;
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("frz_%0d", k), led, 8'hFD);
        end
        enable = 1'b1; mode = 2'd1;
        step();
        check("frz_resume1", led, 8'hFD);
        step();
        check("frz_resume2", led, 8'hFB);

        // Blink on switch 2: dark from tick edge 4 to 7, lit 8 to 11.
        do_reset();
        mode = 2'd3; switch = 3'd2;
        for (int k = 1; k <= 9; k++) begin
            step();
            check($sformatf("blink_k%0d", k), led,
                  (blink_en && ((k / 4) % 2 == 1)) ? 8'hFF : 8'hFB);
        end
        rst = 1'b1;
        step();
        check("blink_rst", led, 8'hFF);
        rst = 1'b0;
        step();
        check("blink_resume", led, 8'hFB);

        // Reset wins over a deasserted enable.
        enable = 1'b0; rst = 1'b1;
        step();
        check("rst_over_en", led, 8'hFF);
        rst = 1'b0;
        step();
        check("rst_hold_dis", led, 8'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
